ps2_frame_receiver: RTL and testbench
=====================================

// Module: ps2_frame_receiver
// PURPOSE
//  Front-end PS/2 device-to-host receiver feeding the keyboard scan-code FIFO in the keyboard decoder.
//  Synchronises and deglitches the raw PS2_CLK/PS2_DAT pins and deserialises 11-bit frames
//  (start, 8 data LSB-first, odd parity, stop).
//  Emits one-cycle kbdcode/kbdcodeValid strobes for good frames and frameErr for bad/aborted ones.
//  Receive-only: never drives the PS/2 lines.
// PARAMETERS
//  FILTER_LEN      8      consecutive equal clk samples required to change filtered PS2_CLK level (>=2)
//  TIMEOUT_CYCLES  54000  idle clk cycles inside a frame before abort (2 ms @ 27 MHz); counter width $clog2(TIMEOUT_CYCLES+1)
// PORTS
//  clk           in   1  system clock
//  resetn        in   1  asynchronous active-low reset
//  PS2_CLK       in   1  raw PS/2 clock pin, asynchronous
//  PS2_DAT       in   1  raw PS/2 data pin, asynchronous
//  kbdcode       out  8  last good scan code; holds value between frames
//  kbdcodeValid  out  1  1-cycle pulse, kbdcode valid this cycle
//  frameErr      out  1  1-cycle pulse: bad start/parity/stop, or timeout
//  busy          out  1  high while FSM is not IDLE
// BEHAVIOUR
//  Reset (async, all regs): kbdcode=0, kbdcodeValid=0, frameErr=0, busy=0, FSM=IDLE.
//   Sync flops reset to 1; filter reset to all-ones, filtered clk=1, so no false edge on reset release.
//  Sync: 2-flop synchroniser on each pin.
//   Filter: FILTER_LEN-deep shift register on synced clk.
//   Filtered clk goes 0 only when all taps are 0, goes 1 only when all taps are 1, else holds; registered.
//  Fall event = registered filtered clk 1->0.
//   Data is sampled from the synced PS2_DAT at the fall event; data is stable for >=5 us around the edge.
//  FSM (all transitions on fall event only, except timeout):
//   IDLE  : dat=0 -> DATA, bitcnt=0, shreg cleared; dat=1 -> stay IDLE, no error (noise).
//   DATA  : shreg={dat,shreg[7:1]}; bitcnt++; after 8th bit -> PARITY.
//   PARITY: capture dat as parity bit -> STOP.
//   STOP  : good if dat=1 and ^{shreg,parity}=1 (odd) -> kbdcode<=shreg, kbdcodeValid=1.
//           Otherwise frameErr=1 and kbdcode is unchanged. Either way -> IDLE.
//  Timeout: idle counter clears on every fall event and while in IDLE, and increments otherwise.
//   Reaching TIMEOUT_CYCLES -> frameErr=1, FSM=IDLE, partial data discarded.
//   A fall event in the same cycle as terminal count: the edge wins, counter clears, no error.
//  Latency: raw PS2_CLK falling edge of stop bit -> kbdcodeValid high exactly FILTER_LEN+4 clk
//   (2 sync, FILTER_LEN fill, 1 filter reg, 1 output reg).
//  kbdcodeValid and frameErr are registered and mutually exclusive, never high 2 consecutive cycles.
//  No backpressure: strobe is fire-and-forget, downstream FIFO must accept or drop.
//  Glitches shorter than FILTER_LEN clk on PS2_CLK are invisible; PS2_DAT is not filtered.
//  Reset asserted mid-frame: immediate abort, no strobe; next frame must begin with a start bit.
// STRUCTURE
//  vgaminikbd.vh: PS/2 FSM state encodings (IDLE/DATA/PARITY/STOP), frame bit counts,
//   default FILTER_LEN/TIMEOUT_CYCLES.
//  One sub-module ps2_line_filter (FILTER_LEN param): 2-flop sync + majority-all filter + fall-event
//   output, used for PS2_CLK.
//  PS2_DAT uses a plain 2-flop sync in the top.
// TESTING (FILTER_LEN=8, TIMEOUT_CYCLES=1000, PS/2 half-period 200 clk)
//  1 Frame 0x1C, parity 0, stop 1 -> one kbdcodeValid, kbdcode=8'h1C, exactly 12 clk after last fall.
//  2 Frames F0 (parity 1) then 1C back-to-back -> two pulses: 8'hF0 then 8'h1C, no frameErr.
//  3 Frame 0x1C sent with parity 1 -> frameErr pulse, no kbdcodeValid, kbdcode keeps prior value.
//  4 Stop bit 0, and separately start bit 1 -> frameErr for bad stop; start=1 ignored silently.
//  5 Stop after 4 data bits -> frameErr 1000 clk after last fall, busy drops.
//    Then a full 0x29 frame -> kbdcodeValid, kbdcode=8'h29.
//  6 5-clk low glitches on PS2_CLK mid-frame plus resetn pulse mid-frame -> no extra bits.
//    After reset all outputs are 0; a subsequent 0x5A frame decodes correctly.

Source files
------------

// File: rtl/ps2_frame_receiver_pkg.sv
// ---------------------------------------------------------------------------
// ps2_frame_receiver_pkg
//   Shared definitions for the PS/2 device-to-host frame receiver:
//   FSM state encodings, frame geometry, default filter/timeout settings
//   and the odd-parity helper used when a frame is closed out.
// ---------------------------------------------------------------------------
package ps2_frame_receiver_pkg;

    // Receiver FSM states. A frame is start, 8 data bits, parity, stop.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_t;

    localparam int DATA_BITS = 8;

    // Defaults sized for a 27 MHz system clock.
    localparam int DEFAULT_FILTER_LEN     = 8;
    localparam int DEFAULT_TIMEOUT_CYCLES = 54000;  // 2 ms

    // PS/2 uses odd parity over the data byte plus the parity bit.
    function automatic logic odd_parity_ok(input logic [DATA_BITS-1:0] data,
                                           input logic                 parity);
        return ^{data, parity};
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// ---------------------------------------------------------------------------
// ps2_line_filter
//   Two-flop synchroniser followed by an all-taps-agree deglitch filter for
//   the raw PS/2 clock pin. The filtered level only moves once FILTER_LEN
//   consecutive synchronised samples agree; a one-cycle strobe marks each
//   filtered 1->0 transition.
//
//   Ports
//     clk     in   system clock
//     resetn  in   asynchronous active-low reset
//     line    in   raw asynchronous pin
//     fall    out  one-cycle strobe on a filtered falling edge
// ---------------------------------------------------------------------------
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic resetn,
    input  logic line,
    output logic fall
);

    logic [1:0]            sync_q;
    logic [FILTER_LEN-1:0] taps_q;
    logic                  level_q;
    logic                  level_d_q;

    // NOTE: the tap shift register is reset along with everything else. A
    // PS/2 line idles high, so an all-ones reset value means the filter
    // starts in agreement with the idle line and cannot fabricate a falling
    // edge when reset releases.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_q    <= '1;
            taps_q    <= '1;
            level_q   <= 1'b1;
            level_d_q <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments here make every stage sample
            // the value its predecessor held before this edge, which is
            // what turns these lines into a pipeline instead of a wire.
            sync_q    <= {sync_q[0], line};
            taps_q    <= {taps_q[FILTER_LEN-2:0], sync_q[1]};
            if (taps_q == '0) begin
                level_q <= 1'b0;
            end else if (&taps_q) begin
                level_q <= 1'b1;
            end
            level_d_q <= level_q;
        end
    end

    assign fall = level_d_q & ~level_q;

endmodule

// File: rtl/ps2_frame_receiver.sv
// ---------------------------------------------------------------------------
// ps2_frame_receiver
//   Receive-only PS/2 device-to-host front end. Deglitches PS2_CLK,
//   synchronises PS2_DAT and deserialises 11-bit frames (start, 8 data bits
//   LSB first, odd parity, stop). Good frames produce a one-cycle
//   kbdcodeValid with the byte on kbdcode; malformed or stalled frames
//   produce a one-cycle frameErr. There is no backpressure: downstream must
//   take the strobe when it fires.
//
//   Ports
//     clk           in   system clock
//     resetn        in   asynchronous active-low reset
//     PS2_CLK       in   raw PS/2 clock pin (asynchronous)
//     PS2_DAT       in   raw PS/2 data pin (asynchronous)
//     kbdcode       out  last good scan code, held between frames
//     kbdcodeValid  out  one-cycle strobe, kbdcode valid this cycle
//     frameErr      out  one-cycle strobe: bad start/parity/stop or timeout
//     busy          out  high while a frame is in progress
// ---------------------------------------------------------------------------
module ps2_frame_receiver
    import ps2_frame_receiver_pkg::*;
#(
    parameter int FILTER_LEN     = DEFAULT_FILTER_LEN,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 PS2_CLK,
    input  logic                 PS2_DAT,
    output logic [DATA_BITS-1:0] kbdcode,
    output logic                 kbdcodeValid,
    output logic                 frameErr,
    output logic                 busy
);

    localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam int                BIT_W    = $clog2(DATA_BITS);
    localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(DATA_BITS - 1);

    // -----------------------------------------------------------------------
    // Pin conditioning
    // -----------------------------------------------------------------------
    logic       clk_fall;
    logic [1:0] dat_sync_q;
    logic       dat;

    ps2_line_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_clk_filter (
        .clk    (clk),
        .resetn (resetn),
        .line   (PS2_CLK),
        .fall   (clk_fall)
    );

    // Data is held stable for microseconds around the clock edge, so a plain
    // synchroniser is enough; the filter latency on the clock path only
    // moves the sample point further into the stable window.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dat_sync_q <= 2'b11;
        end else begin
            dat_sync_q <= {dat_sync_q[0], PS2_DAT};
        end
    end

    assign dat = dat_sync_q[1];

    // -----------------------------------------------------------------------
    // Frame FSM with idle timeout
    // -----------------------------------------------------------------------
    ps2_state_t           state;
    logic [BIT_W-1:0]     bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 parity_q;
    logic [CNT_W-1:0]     idle_cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= ST_IDLE;
            bit_cnt      <= '0;
            shreg        <= '0;
            parity_q     <= 1'b0;
            idle_cnt     <= '0;
            kbdcode      <= '0;
            kbdcodeValid <= 1'b0;
            frameErr     <= 1'b0;
            busy         <= 1'b0;
        end else begin
            // Strobes default low so each one lasts exactly one cycle.
            kbdcodeValid <= 1'b0;
            frameErr     <= 1'b0;

            // Counts cycles since the last clock fall while a frame is open.
            if (clk_fall || state == ST_IDLE) begin
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + 1'b1;
            end

            if (clk_fall) begin
                // A fall arriving on the terminal count wins over the
                // timeout: the frame is still alive.
                unique case (state)
                    ST_IDLE: begin
                        // A high data line at a fall is noise, not a start.
                        if (!dat) begin
                            state   <= ST_DATA;
                            bit_cnt <= '0;
                            shreg   <= '0;
                            busy    <= 1'b1;
                        end
                    end
                    ST_DATA: begin
                        shreg   <= {dat, shreg[DATA_BITS-1:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == BIT_LAST) begin
                            state <= ST_PARITY;
                        end
                    end
                    ST_PARITY: begin
                        parity_q <= dat;
                        state    <= ST_STOP;
                    end
                    ST_STOP: begin
                        if (dat && odd_parity_ok(shreg, parity_q)) begin
                            kbdcode      <= shreg;
                            kbdcodeValid <= 1'b1;
                        end else begin
                            frameErr <= 1'b1;
                        end
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end else if (state != ST_IDLE && idle_cnt == CNT_LAST) begin
                // Device stalled mid-frame: drop the partial byte.
                frameErr <= 1'b1;
                state    <= ST_IDLE;
                busy     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_frame_receiver.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_ps2_frame_receiver
//   Directed bench for ps2_frame_receiver (FILTER_LEN=8, TIMEOUT_CYCLES=1000,
//   PS/2 half-period 200 clk). Frame tasks push the strobe each frame should
//   produce (kind, kbdcode, exact cycle) into a scoreboard queue; a monitor
//   on the falling system-clock edge pops and compares whenever a strobe
//   appears.
// ---------------------------------------------------------------------------
module tb_ps2_frame_receiver;

    localparam int FILTER_LEN     = 8;
    localparam int TIMEOUT_CYCLES = 1000;
    localparam int HALF           = 200;
    localparam int LAT            = FILTER_LEN + 4;

    logic       clk     = 1'b0;
    logic       resetn  = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_dat = 1'b1;
    logic [7:0] kbdcode;
    logic       kbdcode_valid;
    logic       frame_err;
    logic       busy;

    ps2_frame_receiver #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .PS2_CLK      (ps2_clk),
        .PS2_DAT      (ps2_dat),
        .kbdcode      (kbdcode),
        .kbdcodeValid (kbdcode_valid),
        .frameErr     (frame_err),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic       is_err;
        logic [7:0] code;
        int         cyc;
    } exp_t;

    exp_t       sb[$];
    exp_t       arm_e;
    exp_t       mon_e;
    logic       arm        = 1'b0;
    logic [7:0] model_code = 8'h00;
    int         last_fall  = 0;
    int         checks     = 0;
    int         errors     = 0;
    logic       prev_evt   = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One PS/2 bit: data set while clock is high, then a full low half.
    task automatic ps2_bit(input logic b, input logic glitch);
        ps2_dat = b;
        if (glitch) begin
            wait_clks(HALF / 2);
            ps2_clk = 1'b0;
            wait_clks(5);
            ps2_clk = 1'b1;
            wait_clks(HALF / 2 - 5);
        end else begin
            wait_clks(HALF);
        end
        ps2_clk   = 1'b0;
        last_fall = cyc;
        if (arm) begin
            arm_e.cyc = cyc + LAT;
            sb.push_back(arm_e);
            arm = 1'b0;
        end
        wait_clks(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic ps2_frame(input logic [7:0] d, input logic par, input logic stop_b,
                             input logic glitch, input logic expect_good);
        ps2_bit(1'b0, glitch);
        for (int i = 0; i < 8; i++) ps2_bit(d[i], glitch);
        ps2_bit(par, glitch);
        if (expect_good) model_code = d;
        arm_e.is_err = !expect_good;
        arm_e.code   = model_code;
        arm          = 1'b1;
        ps2_bit(stop_b, glitch);
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        check(tag, 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    // Strobe monitor / scoreboard consumer.
    always @(negedge clk) begin
        if (kbdcode_valid || frame_err) begin
            check("strobe_exclusive", 32'(kbdcode_valid & frame_err), 32'd0);
            check("strobe_back_to_back", 32'(prev_evt), 32'd0);
            check("strobe_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                check("strobe_kind_err", 32'(frame_err), 32'(mon_e.is_err));
                check("strobe_kbdcode", 32'(kbdcode), 32'(mon_e.code));
                check("strobe_cycle", 32'(cyc), 32'(mon_e.cyc));
            end
        end
        prev_evt = kbdcode_valid || frame_err;
    end

    initial begin
        repeat (95000) @(posedge clk);
        $display("FAIL watchdog: run exceeded cycle budget");
        $fatal(1);
    end

    initial begin
        // Reset state
        resetn = 1'b0;
        wait_clks(5);
        check("reset_kbdcode", 32'(kbdcode), 32'h00);
        check("reset_valid", 32'(kbdcode_valid), 32'd0);
        check("reset_err", 32'(frame_err), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        resetn = 1'b1;
        wait_clks(20);
        check("release_busy", 32'(busy), 32'd0);

        // 1: single good frame 0x1C, parity 0
        ps2_frame(8'h1C, 1'b0, 1'b1, 1'b0, 1'b1);
        drain("t1_drain", 50);
        check("t1_kbdcode_held", 32'(kbdcode), 32'h1C);
        check("t1_busy", 32'(busy), 32'd0);

        // 2: back-to-back F0 then 1C
        ps2_frame(8'hF0, 1'b1, 1'b1, 1'b0, 1'b1);
        ps2_frame(8'h1C, 1'b0, 1'b1, 1'b0, 1'b1);
        drain("t2_drain", 50);

        // 3: bad parity keeps the previous code
        ps2_frame(8'h1C, 1'b1, 1'b1, 1'b0, 1'b0);
        drain("t3_drain", 50);
        check("t3_kbdcode_held", 32'(kbdcode), 32'h1C);

        // 4: bad stop bit, then a lone clock pulse with data high
        ps2_frame(8'h1C, 1'b0, 1'b0, 1'b0, 1'b0);
        drain("t4_drain", 50);
        ps2_bit(1'b1, 1'b0);
        wait_clks(50);
        check("t4_start1_busy", 32'(busy), 32'd0);
        check("t4_start1_kbdcode", 32'(kbdcode), 32'h1C);

        // 5: stall after 4 data bits -> timeout, then a good 0x29
        ps2_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(i[0], 1'b0);
        check("t5_busy_mid", 32'(busy), 32'd1);
        mon_e.is_err = 1'b1;
        mon_e.code   = model_code;
        mon_e.cyc    = last_fall + LAT + TIMEOUT_CYCLES;
        sb.push_back(mon_e);
        drain("t5_timeout_drain", 1500);
        check("t5_busy_after_timeout", 32'(busy), 32'd0);
        ps2_frame(8'h29, 1'b0, 1'b1, 1'b0, 1'b1);
        drain("t5_frame_drain", 50);

        // 6: short low glitches mid-frame, then reset mid-frame
        ps2_frame(8'h74, 1'b1, 1'b1, 1'b1, 1'b1);
        drain("t6_glitch_drain", 50);
        ps2_bit(1'b0, 1'b0);
        ps2_bit(1'b0, 1'b0);
        ps2_bit(1'b1, 1'b0);
        ps2_bit(1'b0, 1'b0);
        check("t6_busy_mid", 32'(busy), 32'd1);
        resetn = 1'b0;
        wait_clks(3);
        model_code = 8'h00;
        check("t6_reset_kbdcode", 32'(kbdcode), 32'h00);
        check("t6_reset_busy", 32'(busy), 32'd0);
        check("t6_reset_valid", 32'(kbdcode_valid), 32'd0);
        check("t6_reset_err", 32'(frame_err), 32'd0);
        resetn = 1'b1;
        wait_clks(300);
        check("t6_post_reset_busy", 32'(busy), 32'd0);
        ps2_frame(8'h5A, 1'b1, 1'b1, 1'b0, 1'b1);
        drain("t6_frame_drain", 50);
        check("t6_final_kbdcode", 32'(kbdcode), 32'h5A);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
